// File: rtl/camera_capture.sv
// camera_capture
//
// Upstream feeder of the detection state machine. Takes an RGB565 byte
// stream from the camera interface (already in the clk domain, qualified by
// byte_en), decimates it by DEC in both x and y, converts each kept pixel to
// 8-bit grey and writes it to frame memory. cap_done is high between
// completed frames and low while a frame is being written.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   byte_en       one-cycle strobe: cam_data holds a valid camera byte
//   vsync         frame sync, high = vertical blanking
//   href          line valid, bytes count only while high
//   cam_data      camera byte (first = RGB565[15:8], second = [7:0])
//   write_en_out  one-cycle memory write strobe
//   wr_addr       memory write address
//   wr_data       grey pixel
//   cap_done      high = last frame complete, no frame in progress
//   frame_err     high = last frame wrote a pixel count other than OUT_PIXELS

module camera_capture #(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int DEC        = 4,
    parameter int OUT_PIXELS = 19200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_data,
    output logic        write_en_out,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cap_done,
    output logic        frame_err
);

    // Counter widths: x and line counters saturate at the source size, the
    // pixel count must reach OUT_PIXELS (up to 32768) so it needs 16 bits.
    localparam int XW = $clog2(SRC_WIDTH + 1);
    localparam int LW = $clog2(SRC_HEIGHT + 1);

    localparam logic [XW-1:0] SRC_WIDTH_X  = XW'(SRC_WIDTH);
    localparam logic [LW-1:0] SRC_HEIGHT_L = LW'(SRC_HEIGHT);
    localparam logic [XW-1:0] DEC_MASK_X   = XW'(DEC - 1);
    localparam logic [LW-1:0] DEC_MASK_L   = LW'(DEC - 1);
    localparam logic [15:0]   OUT_PIX_C    = 16'(OUT_PIXELS);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          vsync_prev_q, href_prev_q;
    logic [XW-1:0] x_q, x_d;
    logic [LW-1:0] line_q, line_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   pix_cnt_q, pix_cnt_d;
    logic          write_en_q, write_en_d;
    logic [14:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          cap_done_q, cap_done_d;
    logic          frame_err_q, frame_err_d;

    logic          vsync_rise, vsync_fall, href_rise, href_fall;
    logic [XW-1:0] x_cur;
    logic          phase_cur;
    logic          keep;
    logic [15:0]   pix_cnt_nxt;
    logic [15:0]   pixel;
    logic [7:0]    r8, g8, b8;
    logic [9:0]    grey_sum;

    // Edges are always taken against the registered copies of vsync/href.
    assign vsync_rise = ~vsync_prev_q &  vsync;
    assign vsync_fall =  vsync_prev_q & ~vsync;
    assign href_rise  = ~href_prev_q  &  href;
    assign href_fall  =  href_prev_q  & ~href;

    // Grey conversion: channels expanded to 8 bits by bit replication, then
    // (r + 2g + b) / 4, which fits in 10 bits without overflow.
    always_comb begin
        pixel    = {hi_q, cam_data};
        r8       = {pixel[15:11], pixel[15:13]};
        g8       = {pixel[10:5], pixel[10:9]};
        b8       = {pixel[4:0], pixel[4:2]};
        grey_sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
    end

    // A line start resets x and the byte phase in the same cycle, so a byte
    // arriving together with the href rising edge is already the first byte.
    always_comb begin
        x_cur     = href_rise ? '0 : x_q;
        phase_cur = href_rise ? 1'b0 : phase_q;
        keep      = ((x_cur & DEC_MASK_X) == '0) &&
                    ((line_q & DEC_MASK_L) == '0) &&
                    (x_cur < SRC_WIDTH_X) &&
                    (line_q < SRC_HEIGHT_L) &&
                    (pix_cnt_q < OUT_PIX_C);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        line_d      = line_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        pix_cnt_d   = pix_cnt_q;
        pix_cnt_nxt = pix_cnt_q;
        write_en_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cap_done_d  = cap_done_q;
        frame_err_d = frame_err_q;

        case (state_q)
            WAIT_SYNC, DONE: begin
                if (vsync_fall) begin
                    wr_addr_d  = '0;
                    line_d     = '0;
                    x_d        = '0;
                    phase_d    = 1'b0;
                    pix_cnt_d  = '0;
                    cap_done_d = 1'b0;
                    state_d    = ACTIVE;
                end
            end

            ACTIVE: begin
                x_d     = x_cur;
                phase_d = phase_cur;

                if (byte_en && href) begin
                    if (!phase_cur) begin
                        hi_d    = cam_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (keep) begin
                            write_en_d  = 1'b1;
                            wr_addr_d   = pix_cnt_q[14:0];
                            wr_data_d   = 8'(grey_sum >> 2);
                            pix_cnt_nxt = pix_cnt_q + 16'd1;
                        end
                        if (x_cur < SRC_WIDTH_X) begin
                            x_d = x_cur + 1'b1;
                        end
                    end
                end
                pix_cnt_d = pix_cnt_nxt;

                // A half pixel left at the end of a line is dropped.
                if (href_fall) begin
                    phase_d = 1'b0;
                    if (line_q < SRC_HEIGHT_L) begin
                        line_d = line_q + 1'b1;
                    end
                end

                // The error check uses the count including a pixel completed
                // in this very cycle, whose write appears one cycle later.
                if (vsync_rise) begin
                    cap_done_d  = 1'b1;
                    frame_err_d = (pix_cnt_nxt != OUT_PIX_C);
                    state_d     = DONE;
                end
            end

            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    // vsync_prev_q resets to 0, so a frame already running at reset never
    // produces a falling edge and is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_SYNC;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            x_q          <= '0;
            line_q       <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pix_cnt_q    <= '0;
            write_en_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cap_done_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_prev_q <= vsync;
            href_prev_q  <= href;
            x_q          <= x_d;
            line_q       <= line_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            pix_cnt_q    <= pix_cnt_d;
            write_en_q   <= write_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cap_done_q   <= cap_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign write_en_out = write_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cap_done     = cap_done_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture
//
// Drives camera frames of various shapes into camera_capture (8x4 source,
// decimation 2, 8 output pixels). The frame driver predicts every memory
// write from the decimation and grey-conversion rules and queues it; a
// separate monitor pops and compares whenever write_en_out is seen.

module tb_camera_capture;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int DEC = 2;
    localparam int OUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_en;
    logic        vsync;
    logic        href;
    logic [7:0]  cam_data;
    logic        write_en_out;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cap_done;
    logic        frame_err;

    camera_capture #(
        .SRC_WIDTH (W),
        .SRC_HEIGHT(H),
        .DEC       (DEC),
        .OUT_PIXELS(OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_en     (byte_en),
        .vsync       (vsync),
        .href        (href),
        .cam_data    (cam_data),
        .write_en_out(write_en_out),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cap_done    (cap_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Number of rising clock edges seen so far; used to time-stamp writes.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int when;
    } wr_t;

    wr_t exp_q[$];
    int  errors   = 0;
    int  checks   = 0;
    int  kept     = 0;
    int  prev_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference grey value: replicate channel bits, weight green twice, /4.
    function automatic int greyRef(input int p);
        int r5, g6, b5, r8, g8, b8;
        r5 = (p >> 11) & 31;
        g6 = (p >> 5) & 63;
        b5 = p & 31;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (r8 + 2 * g8 + b8) / 4;
    endfunction

    function automatic int pixVal(input int mode, input int l, input int x);
        if (mode == 0) return 'hFFFF;
        if (mode == 1 && l == 0 && x == 0) return 'hF800;
        if (mode == 1 && l == 0 && x == 2) return 'h07E0;
        if (mode == 1 && l == 0 && x == 4) return 'h001F;
        return int'($urandom_range(0, 65535));
    endfunction

    function automatic bit isKept(input int l, input int x);
        return (x % DEC == 0) && (l % DEC == 0) && (x < W) && (l < H) && (kept < OUT);
    endfunction

    task automatic driveByte(input logic [7:0] b, input bit raise_vs);
        byte_en  = 1'b1;
        cam_data = b;
        if (raise_vs) vsync = 1'b1;
        step();
        byte_en  = 1'b0;
        cam_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) step();
    endtask

    // One line of npix complete pixels, an optional odd trailing byte, and
    // optionally a stray strobe on the href falling edge (must be ignored).
    task automatic driveLine(input int l, input int npix, input bit odd, input int mode,
                             input bit raise_last, input bit garbage, input bit model_on);
        int v;
        href = 1'b1;
        step();
        for (int x = 0; x < npix; x++) begin
            v = pixVal(mode, l, x);
            driveByte(8'(v >> 8), 1'b0);
            if (model_on && isKept(l, x)) begin
                exp_q.push_back('{kept, greyRef(v), cyc + 1});
                kept++;
            end
            driveByte(8'(v), raise_last && (x == npix - 1));
        end
        if (odd) driveByte(8'($urandom), 1'b0);
        href     = 1'b0;
        byte_en  = garbage;
        cam_data = 8'($urandom);
        step();
        byte_en = 1'b0;
        repeat (2) step();
    endtask

    // One full frame starting from blanking (vsync high).
    task automatic applyStimulus(input int nlines, input int npix, input bit odd, input int mode,
                                 input bit raise_last, input bit random_shape);
        int  np;
        bit  od;
        bit  rl;
        repeat (2) step();
        vsync = 1'b0;
        kept  = 0;
        step();
        step();
        checkOutput("cap_done_low_in_frame", cap_done, 0);
        checkOutput("frame_err_held", frame_err, prev_err);
        for (int l = 0; l < nlines; l++) begin
            np = npix;
            od = odd;
            if (random_shape) begin
                np = $urandom_range(3, 10);
                od = 1'($urandom_range(0, 1));
            end
            rl = raise_last && (l == nlines - 1);
            if (rl) od = 1'b0;
            driveLine(l, np, od, mode, rl, 1'($urandom_range(0, 1)), 1'b1);
        end
        if (!raise_last) begin
            vsync = 1'b1;
            step();
        end
        repeat (3) step();
        prev_err = (kept != OUT) ? 1 : 0;
        checkOutput("cap_done_at_frame_end", cap_done, 1);
        checkOutput("frame_err_at_frame_end", frame_err, prev_err);
        checkOutput("writes_outstanding", exp_q.size(), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_write_en"}, write_en_out, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_cap_done"}, cap_done, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && write_en_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got write at addr 0x%0h data 0x%0h, required no write (cycle %0d)",
                             wr_addr, wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", wr_addr, e.addr);
                    checkOutput("wr_data", wr_data, e.data);
                    checkOutput("write_cycle", cyc, e.when);
                end
            end
        end
    end

    // Time bound so the bench always ends.
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL timeout: simulation still running at %0t, required completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int v;
        rst      = 1'b1;
        byte_en  = 1'b0;
        vsync    = 1'b1;
        href     = 1'b0;
        cam_data = 8'h00;

        // Reset holds all outputs at zero even with activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            byte_en  = 1'($urandom_range(0, 1));
            cam_data = 8'($urandom);
            step();
            checkAllZero("reset");
        end
        byte_en = 1'b0;
        rst     = 1'b0;
        step();
        step();
        checkOutput("cap_done_before_sync", cap_done, 0);

        applyStimulus(4, 8, 1'b0, 0, 1'b0, 1'b0);   // full frame, all 0xFFFF
        applyStimulus(4, 8, 1'b0, 1, 1'b0, 1'b0);   // grey arithmetic pixels
        applyStimulus(2, 8, 1'b0, 2, 1'b0, 1'b0);   // short frame
        applyStimulus(6, 8, 1'b0, 2, 1'b0, 1'b0);   // long frame
        applyStimulus(3, 7, 1'b0, 2, 1'b1, 1'b0);   // vsync rises with last kept byte
        for (int f = 0; f < 4; f++) begin
            applyStimulus($urandom_range(1, 6), 0, 1'b0, 2, 1'b0, 1'b1);
        end

        // Reset in the middle of a frame after three writes.
        repeat (2) step();
        vsync = 1'b0;
        kept  = 0;
        step();
        step();
        href = 1'b1;
        step();
        for (int x = 0; x < 5; x++) begin
            v = pixVal(2, 0, x);
            driveByte(8'(v >> 8), 1'b0);
            if (isKept(0, x)) begin
                exp_q.push_back('{kept, greyRef(v), cyc + 1});
                kept++;
            end
            driveByte(8'(v), 1'b0);
        end
        driveByte(8'($urandom), 1'b0);
        repeat (3) step();
        checkOutput("writes_before_reset", exp_q.size(), 0);
        rst = 1'b1;
        step();
        checkAllZero("midreset");
        rst = 1'b0;
        for (int b = 0; b < 5; b++) driveByte(8'($urandom), 1'b0);
        href = 1'b0;
        step();
        for (int l = 1; l < 4; l++) driveLine(l, 8, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        vsync = 1'b1;
        step();
        repeat (3) step();
        checkOutput("cap_done_after_aborted_frame", cap_done, 0);
        prev_err = 0;

        // New frame restarts at address 0; lines end with an odd byte.
        applyStimulus(4, 4, 1'b1, 2, 1'b0, 1'b0);

        repeat (5) step();
        checkOutput("queue_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
